alu_seq_operand: RTL
====================

// Module: alu_seq_operand
// PURPOSE
//  Sequential, parametrised ALU with operand fetch, for the MCU datapath. On START it fetches
//  SR1 and SR2 through a handshaked memory read port, executes one of four ops, and registers
//  ANSWER, SR1OUT, SR2OUT and NZP flags. It sits between the control FSM and the ROM/RAM read
//  port. The result reaches the shared bus only while GATEALU is high.
// PARAMETERS
//  DATA_W   16  operand/result width
//  ADDR_W   16  memory address width; every operand pointer is zero-extended to this width
//  IMM_W     8  width of DATA immediate field
//  DIR_W     7  width of ADDRESS direct field
//  RIDX_W    3  width of REGISTER1/REGISTER2 index fields
// PORTS
//  CLK        in   1        clock, rising edge
//  RST_N      in   1        async active-low reset
//  START      in   1        start request; sampled only in IDLE
//  ALUK       in   2        op: 00 PASS SR1, 01 AND, 10 NOT SR1, 11 ADD
//  SR2SELECT  in   2        00 reg, 01 immediate, 10 direct, 11 indirect register
//  REGISTER1  in   RIDX_W   SR1 pointer
//  REGISTER2  in   RIDX_W   SR2 pointer (modes 00/11)
//  DATA       in   IMM_W    immediate (mode 01)
//  ADDRESS    in   DIR_W    direct address (mode 10)
//  GATEALU    in   1        bus gate
//  MEM_REQ    out  1        read request, held until accepted
//  MEM_ADDR   out  ADDR_W   read address, stable while MEM_REQ=1
//  MEM_VALID  in   1        read data valid; a transfer occurs on an edge with MEM_REQ&MEM_VALID
//  MEM_RDATA  in   DATA_W   read data
//  BUSY       out  1        high in every state except IDLE
//  DONE       out  1        one-cycle completion pulse
//  ANSWER     out  DATA_W   registered result, held until the next completion
//  ANSWER_BUS out  DATA_W   GATEALU ? ANSWER : 0, combinational
//  SR1OUT     out  DATA_W   registered SR1 operand
//  SR2OUT     out  DATA_W   registered SR2 operand
//  NZP        out  3        flags of ANSWER: {N,Z,P}; exactly one bit set after the first op
// BEHAVIOUR
//  Reset: all outputs 0 (NZP=000), FSM in IDLE. Reset applies immediately, including mid-fetch:
//   MEM_REQ drops asynchronously and any in-flight response is discarded.
//  Controls latched at START: ALUK, SR2SELECT, REGISTER1/2, DATA and ADDRESS are captured on the
//   accepting edge. Later changes have no effect on the current op.
//  FSM: IDLE -START-> F1 -> [F2 -> [FI]] -> EX -> DN -> IDLE.
//   F1: MEM_ADDR=zext(REGISTER1); on the transfer edge SR1OUT<=MEM_RDATA.
//    SR2SELECT=01: SR2OUT<=zext(DATA) on the same edge; next state EX. Otherwise next state F2.
//   F2: MEM_ADDR=zext(REGISTER2) (modes 00/11) or zext(ADDRESS) (mode 10).
//    Mode 11: data goes to an internal pointer register; next state FI. Other modes: SR2OUT<=data.
//   FI: MEM_ADDR=pointer[ADDR_W-1:0] (truncated or zero-extended); data goes to SR2OUT.
//   EX: ANSWER and NZP are registered from the datapath. DN: DONE=1 for one cycle.
//  Fetch states wait without limit while MEM_VALID=0; MEM_ADDR must not change while waiting.
//  Latency, START edge to DONE high, zero-wait memory: 3 clocks for immediate, 4 for reg/direct,
//   5 for indirect. Each wait cycle adds one clock.
//  START outside IDLE is ignored. No queueing. START held high in DN is accepted in the next IDLE.
//  Arithmetic: ADD is modulo 2^DATA_W (carry dropped). NOT is bitwise. NZP uses a signed view:
//   N=MSB, Z=(ANSWER==0), P=otherwise.
//  MEM_VALID with MEM_REQ=0 is ignored.
// CONFIGURATION
//  ALU_FLAGS_EN defined: adds output ports CARRY and OVERFLOW (1 bit each), registered in EX
//   alongside ANSWER and reset to 0. ADD sets CARRY to the carry-out and OVERFLOW to signed
//   overflow. Any other op clears both.
//  ALU_FLAGS_EN undefined: neither port nor its logic exists. Everything else is identical.
// STRUCTURE
//  alu_pkg holds:
//   ALUK and SR2SELECT encodings as localparams;
//   FSM state encodings (IDLE, F1, F2, FI, EX, DN);
//   zext helper functions.
//  Sub-module alu_seq_core is the combinational datapath: inputs SR1, SR2, ALUK; outputs result,
//   nzp, and carry/ovf. The top level holds the FSM, fetch sequencing and registers.
// TESTING  (bench memory model: mem[] preloaded, configurable wait states)
//  1 Immediate ADD:
//   mem[3]=0x0010, REGISTER1=3, DATA=0x05, SR2SELECT=01, ALUK=11.
//   -> one MEM_REQ at addr 3; ANSWER=0x0015, NZP=001; DONE 3 clocks after START.
//  2 Indirect ADD:
//   mem[1]=0x0001, mem[2]=0x0040, mem[0x40]=0x1234, REGISTER1=1, REGISTER2=2, SR2SELECT=11.
//   -> MEM_ADDR sequence 1,2,0x40; SR2OUT=0x1234, ANSWER=0x1235; DONE after 5 clocks.
//  3 Direct AND with 2 wait cycles per read:
//   mem[4]=0x00FF, mem[0x7F]=0x0F0F, REGISTER1=4, ADDRESS=0x7F, ALUK=01.
//   -> ANSWER=0x000F; DONE after 8 clocks; MEM_ADDR stable while waiting.
//  4 ADD wrap:
//   SR1=0xFFFF, SR2=0x0002 -> ANSWER=0x0001, NZP=001. With ALU_FLAGS_EN: CARRY=1, OVERFLOW=0.
//   NOT of 0x0000 -> ANSWER=0xFFFF, NZP=100.
//  5 Reset and ignore:
//   START during BUSY -> no second op, single DONE. RST_N low while in F2 -> MEM_REQ, BUSY,
//   ANSWER and NZP go to 0 immediately; a new START after release runs normally.
//  6 GATEALU:
//   ANSWER=0x1235 with GATEALU=0 -> ANSWER_BUS=0; GATEALU=1 -> ANSWER_BUS=0x1235 in the same cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings, FSM states and width helpers for alu_seq_operand.
// Build option: ALU_FLAGS_EN adds registered CARRY/OVERFLOW outputs.
package alu_pkg;

    localparam logic [1:0] ALUK_PASS = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_ADD  = 2'b11;

    localparam logic [1:0] SR2_REG = 2'b00;
    localparam logic [1:0] SR2_IMM = 2'b01;
    localparam logic [1:0] SR2_DIR = 2'b10;
    localparam logic [1:0] SR2_IND = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_FI,
        S_EX,
        S_DN
    } state_e;

    // Keeps the low w bits of v and clears the rest; callers cast to the target width.
    function automatic logic [63:0] zext(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return v & mask;
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational ALU datapath: PASS/AND/NOT/ADD with {N,Z,P} flags.
// Build option: ALU_FLAGS_EN adds carry-out and signed-overflow outputs.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] sr1_i,
    input  logic [DATA_W-1:0] sr2_i,
    input  logic [1:0]        aluk_i,
    output logic [DATA_W-1:0] result_o,
    output logic [2:0]        nzp_o
`ifdef ALU_FLAGS_EN
    ,
    output logic              carry_o,
    output logic              ovf_o
`endif
);

    logic [DATA_W-1:0] sum;

    always_comb begin
        sum      = sr1_i + sr2_i;
        result_o = '0;
        case (aluk_i)
            ALUK_PASS: result_o = sr1_i;
            ALUK_AND:  result_o = sr1_i & sr2_i;
            ALUK_NOT:  result_o = ~sr1_i;
            default:   result_o = sum;
        endcase
        if (result_o[DATA_W-1])
            nzp_o = 3'b100;
        else if (result_o == '0)
            nzp_o = 3'b010;
        else
            nzp_o = 3'b001;
    end

`ifdef ALU_FLAGS_EN
    logic a_msb, b_msb, s_msb;

    // Carry-out recovered from the operand and sum MSBs, so no extra adder bit is needed.
    always_comb begin
        a_msb   = sr1_i[DATA_W-1];
        b_msb   = sr2_i[DATA_W-1];
        s_msb   = sum[DATA_W-1];
        carry_o = 1'b0;
        ovf_o   = 1'b0;
        if (aluk_i == ALUK_ADD) begin
            carry_o = (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
            ovf_o   = (a_msb == b_msb) && (s_msb != a_msb);
        end
    end
`endif

endmodule

// File: rtl/alu_seq_operand.sv
// Sequential ALU: fetches SR1/SR2 over a handshaked read port, executes, registers result and flags.
// Build option: ALU_FLAGS_EN adds CARRY and OVERFLOW output ports.
module alu_seq_operand
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned DIR_W  = 7,
    parameter int unsigned RIDX_W = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [1:0]        ALUK,
    input  logic [1:0]        SR2SELECT,
    input  logic [RIDX_W-1:0] REGISTER1,
    input  logic [RIDX_W-1:0] REGISTER2,
    input  logic [IMM_W-1:0]  DATA,
    input  logic [DIR_W-1:0]  ADDRESS,
    input  logic              GATEALU,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_VALID,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] ANSWER,
    output logic [DATA_W-1:0] ANSWER_BUS,
    output logic [DATA_W-1:0] SR1OUT,
    output logic [DATA_W-1:0] SR2OUT,
    output logic [2:0]        NZP
`ifdef ALU_FLAGS_EN
    ,
    output logic              CARRY,
    output logic              OVERFLOW
`endif
);

    state_e              state_q;
    logic [1:0]          aluk_q, sel_q;
    logic [RIDX_W-1:0]   reg2_q;
    logic [IMM_W-1:0]    data_q;
    logic [DIR_W-1:0]    dir_q;
    logic                mem_req_q, done_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   sr1_q, sr2_q, answer_q;
    logic [2:0]          nzp_q;
    logic [DATA_W-1:0]   alu_result;
    logic [2:0]          alu_nzp;
    logic                xfer;

`ifdef ALU_FLAGS_EN
    logic carry_q, ovf_q, alu_carry, alu_ovf;
`endif

    alu_seq_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .sr1_i    (sr1_q),
        .sr2_i    (sr2_q),
        .aluk_i   (aluk_q),
        .result_o (alu_result),
        .nzp_o    (alu_nzp)
`ifdef ALU_FLAGS_EN
        ,
        .carry_o  (alu_carry),
        .ovf_o    (alu_ovf)
`endif
    );

    assign xfer = mem_req_q & MEM_VALID;

    // The next fetch address is loaded on the transfer edge, so MEM_ADDR is a plain register
    // and stays stable for the whole wait; in indirect mode it doubles as the pointer register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            aluk_q     <= '0;
            sel_q      <= '0;
            reg2_q     <= '0;
            data_q     <= '0;
            dir_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            sr1_q      <= '0;
            sr2_q      <= '0;
            answer_q   <= '0;
            nzp_q      <= '0;
`ifdef ALU_FLAGS_EN
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (START) begin
                    aluk_q     <= ALUK;
                    sel_q      <= SR2SELECT;
                    reg2_q     <= REGISTER2;
                    data_q     <= DATA;
                    dir_q      <= ADDRESS;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= ADDR_W'(zext(64'(REGISTER1), RIDX_W));
                    state_q    <= S_F1;
                end
                S_F1: if (xfer) begin
                    sr1_q <= MEM_RDATA;
                    if (sel_q == SR2_IMM) begin
                        sr2_q     <= DATA_W'(zext(64'(data_q), IMM_W));
                        mem_req_q <= 1'b0;
                        state_q   <= S_EX;
                    end else begin
                        mem_addr_q <= (sel_q == SR2_DIR) ? ADDR_W'(zext(64'(dir_q), DIR_W))
                                                         : ADDR_W'(zext(64'(reg2_q), RIDX_W));
                        state_q    <= S_F2;
                    end
                end
                S_F2: if (xfer) begin
                    if (sel_q == SR2_IND) begin
                        mem_addr_q <= ADDR_W'(zext(64'(MEM_RDATA), ADDR_W));
                        state_q    <= S_FI;
                    end else begin
                        sr2_q     <= MEM_RDATA;
                        mem_req_q <= 1'b0;
                        state_q   <= S_EX;
                    end
                end
                S_FI: if (xfer) begin
                    sr2_q     <= MEM_RDATA;
                    mem_req_q <= 1'b0;
                    state_q   <= S_EX;
                end
                S_EX: begin
                    answer_q <= alu_result;
                    nzp_q    <= alu_nzp;
`ifdef ALU_FLAGS_EN
                    carry_q  <= alu_carry;
                    ovf_q    <= alu_ovf;
`endif
                    done_q   <= 1'b1;
                    state_q  <= S_DN;
                end
                S_DN:    state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MEM_REQ    = mem_req_q;
    assign MEM_ADDR   = mem_addr_q;
    assign BUSY       = (state_q != S_IDLE);
    assign DONE       = done_q;
    assign ANSWER     = answer_q;
    assign ANSWER_BUS = GATEALU ? answer_q : '0;
    assign SR1OUT     = sr1_q;
    assign SR2OUT     = sr2_q;
    assign NZP        = nzp_q;
`ifdef ALU_FLAGS_EN
    assign CARRY      = carry_q;
    assign OVERFLOW   = ovf_q;
`endif

endmodule
